i3c_sdr_xfer_buffer: RTL and testbench

- Parametrised TX/RX byte buffering between the APB register file and the SDR private-transfer engine; replaces the single-byte tx/rx data registers.
- TX FIFO: host writes, engine reads during SDR private reads. RX FIFO: engine writes, host reads after SDR private writes.
- Adds overflow/underrun sticky flags and per-transfer byte counting bounded by START/STOP.
- Clocked entirely on clk_apb.

---
 rtl/i3c_pkg.sv | 22 ++
 rtl/i3c_byte_fifo.sv | 68 ++++++
 rtl/i3c_sdr_xfer_buffer.sv | 140 ++++++++++++++
 tb/tb_i3c_sdr_xfer_buffer.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i3c_pkg.sv
// Shared constants for the I3C SDR transfer buffer: flag bit positions,
// default geometry and the TX underrun fill byte.
package i3c_pkg;

    localparam int DEF_DW    = 8;
    localparam int DEF_DEPTH = 16;
    localparam logic [7:0] DEF_UNDERRUN_FILL = 8'hFF;

    localparam int NUM_FLAGS  = 4;
    localparam int FLG_TX_OVF = 0;
    localparam int FLG_TX_UDR = 1;
    localparam int FLG_RX_OVR = 2;
    localparam int FLG_RX_UDF = 3;

    // Adds 0..2 to a 16-bit byte count, sticking at 16'hFFFF.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {15'd0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/i3c_byte_fifo.sv
// Show-ahead byte FIFO with flush and single-cycle overflow/underflow pulses.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module i3c_byte_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf,
    output logic                     udf
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !flush && (!full || pop);
    assign pop_ok  = pop && !flush && !empty;
    assign ovf     = push && !flush && full && !pop;
    assign udf     = pop && !flush && empty;
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the data array is deliberately not reset; after reset the pointers
    // and count make every stale entry unreachable, and the outputs are masked
    // while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/i3c_sdr_xfer_buffer.sv
// TX/RX byte buffering between the APB register file and the SDR engine, with
// sticky error flags and per-transfer byte counting. Optional irq: I3C_XFER_BUF_IRQ_EN.
module i3c_sdr_xfer_buffer
    import i3c_pkg::*;
#(
    parameter int             DW            = DEF_DW,
    parameter int             DEPTH         = DEF_DEPTH,
    parameter logic [DW-1:0]  UNDERRUN_FILL = DW'(DEF_UNDERRUN_FILL),
    parameter bit             AUTO_TX_FLUSH = 1'b0
) (
    input  logic                     clk_apb,
    input  logic                     rst_n,
    input  logic                     host_wr_en,
    input  logic [DW-1:0]            host_wdata,
    input  logic                     host_rd_en,
    output logic [DW-1:0]            host_rdata,
    input  logic                     i3c_rd_en,
    output logic [DW-1:0]            i3c_tx_data,
    input  logic                     i3c_wr_en,
    input  logic [DW-1:0]            i3c_rx_data,
    output logic                     i3c_tx_ready,
    output logic                     i3c_rx_ready,
    input  logic                     start_detected,
    input  logic                     stop_detected,
    input  logic                     tx_flush,
    input  logic                     rx_flush,
    input  logic [3:0]               flag_clr,
    output logic [$clog2(DEPTH):0]   tx_level,
    output logic [$clog2(DEPTH):0]   rx_level,
    output logic [3:0]               flags,
    output logic [15:0]              last_xfer_len,
    output logic                     irq
`ifdef I3C_XFER_BUF_IRQ_EN
    ,
    input  logic [5:0]               irq_mask
`endif
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [DW-1:0] tx_head, rx_head;
    logic          tx_empty, rx_empty, rx_full;
    logic          tx_ovf, tx_udf, rx_ovf, rx_udf;
    logic          tx_clear;
    logic          tx_pop_ok, rx_push_ok;
    logic [1:0]    xfer_step;
    logic [15:0]   xfer_cnt, xfer_next;
    logic [3:0]    flag_set;

    assign tx_clear = tx_flush || (AUTO_TX_FLUSH && stop_detected);

    i3c_byte_fifo #(.DW(DW), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk_apb),
        .rst_n (rst_n),
        .push  (host_wr_en),
        .pop   (i3c_rd_en),
        .flush (tx_clear),
        .wdata (host_wdata),
        .rdata (tx_head),
        .level (tx_level),
        .full  (),
        .empty (tx_empty),
        .ovf   (tx_ovf),
        .udf   (tx_udf)
    );

    i3c_byte_fifo #(.DW(DW), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk_apb),
        .rst_n (rst_n),
        .push  (i3c_wr_en),
        .pop   (host_rd_en),
        .flush (rx_flush),
        .wdata (i3c_rx_data),
        .rdata (rx_head),
        .level (rx_level),
        .full  (rx_full),
        .empty (rx_empty),
        .ovf   (rx_ovf),
        .udf   (rx_udf)
    );

    assign i3c_tx_data  = tx_empty ? UNDERRUN_FILL : tx_head;
    assign host_rdata   = rx_empty ? '0 : rx_head;
    assign i3c_tx_ready = !tx_empty;
    assign i3c_rx_ready = !rx_full;

    // Only bytes the engine actually moved count toward the transfer length.
    assign tx_pop_ok  = i3c_rd_en && !tx_clear && !tx_empty;
    assign rx_push_ok = i3c_wr_en && !rx_flush && (!rx_full || host_rd_en);
    assign xfer_step  = {1'b0, tx_pop_ok} + {1'b0, rx_push_ok};
    assign xfer_next  = sat_add16(xfer_cnt, xfer_step);

    // Stop latches the running count before a coincident start clears it.
    always_ff @(posedge clk_apb or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt      <= '0;
            last_xfer_len <= '0;
        end else begin
            if (stop_detected)  last_xfer_len <= xfer_next;
            if (start_detected) xfer_cnt      <= '0;
            else                xfer_cnt      <= xfer_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        flag_set             = '0;
        flag_set[FLG_TX_OVF] = tx_ovf;
        flag_set[FLG_TX_UDR] = tx_udf;
        flag_set[FLG_RX_OVR] = rx_ovf;
        flag_set[FLG_RX_UDF] = rx_udf;
    end

    always_ff @(posedge clk_apb or negedge rst_n) begin
        if (!rst_n) flags <= '0;
        else        flags <= (flags & ~flag_clr) | flag_set;
    end

`ifdef I3C_XFER_BUF_IRQ_EN
    logic       tx_idle;
    logic [5:0] irq_src;

    assign irq_src = {tx_idle && tx_empty, rx_level >= LW'(DEPTH / 2), flags};

    // irq_mask bit = 1 suppresses the matching source.
    always_ff @(posedge clk_apb or negedge rst_n) begin
        if (!rst_n) begin
            tx_idle <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (stop_detected)   tx_idle <= 1'b1;
            else if (host_wr_en) tx_idle <= 1'b0;
            irq <= |(irq_src & ~irq_mask);
        end
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_i3c_sdr_xfer_buffer.sv
// Self-checking bench for i3c_sdr_xfer_buffer: directed vector table, hand
// sequences for fill/drain corners, and a randomized run against a queue model.
module tb_i3c_sdr_xfer_buffer;

    localparam int DEPTH = 16;

    logic        clk_apb = 1'b0;
    logic        rst_n;
    logic        host_wr_en, host_rd_en, i3c_rd_en, i3c_wr_en;
    logic [7:0]  host_wdata, i3c_rx_data;
    logic        start_detected, stop_detected, tx_flush, rx_flush;
    logic [3:0]  flag_clr;

    logic [7:0]  host_rdata, i3c_tx_data;
    logic        i3c_tx_ready, i3c_rx_ready, irq;
    logic [4:0]  tx_level, rx_level;
    logic [3:0]  flags;
    logic [15:0] last_xfer_len;

    logic [7:0]  host_rdata_2, i3c_tx_data_2;
    logic        i3c_tx_ready_2, i3c_rx_ready_2, irq_2;
    logic [4:0]  tx_level_2, rx_level_2;
    logic [3:0]  flags_2;
    logic [15:0] last_xfer_len_2;

    int checks   = 0;
    int failures = 0;

    always #5 clk_apb = ~clk_apb;

    i3c_sdr_xfer_buffer dut (
        .clk_apb(clk_apb), .rst_n(rst_n),
        .host_wr_en(host_wr_en), .host_wdata(host_wdata),
        .host_rd_en(host_rd_en), .host_rdata(host_rdata),
        .i3c_rd_en(i3c_rd_en), .i3c_tx_data(i3c_tx_data),
        .i3c_wr_en(i3c_wr_en), .i3c_rx_data(i3c_rx_data),
        .i3c_tx_ready(i3c_tx_ready), .i3c_rx_ready(i3c_rx_ready),
        .start_detected(start_detected), .stop_detected(stop_detected),
        .tx_flush(tx_flush), .rx_flush(rx_flush), .flag_clr(flag_clr),
        .tx_level(tx_level), .rx_level(rx_level), .flags(flags),
        .last_xfer_len(last_xfer_len), .irq(irq)
    );

    i3c_sdr_xfer_buffer #(.AUTO_TX_FLUSH(1'b1)) dut_auto (
        .clk_apb(clk_apb), .rst_n(rst_n),
        .host_wr_en(host_wr_en), .host_wdata(host_wdata),
        .host_rd_en(host_rd_en), .host_rdata(host_rdata_2),
        .i3c_rd_en(i3c_rd_en), .i3c_tx_data(i3c_tx_data_2),
        .i3c_wr_en(i3c_wr_en), .i3c_rx_data(i3c_rx_data),
        .i3c_tx_ready(i3c_tx_ready_2), .i3c_rx_ready(i3c_rx_ready_2),
        .start_detected(start_detected), .stop_detected(stop_detected),
        .tx_flush(tx_flush), .rx_flush(rx_flush), .flag_clr(flag_clr),
        .tx_level(tx_level_2), .rx_level(rx_level_2), .flags(flags_2),
        .last_xfer_len(last_xfer_len_2), .irq(irq_2)
    );

    typedef struct {
        logic       hw;   logic [7:0] wd;
        logic       ir;   logic       iw;  logic [7:0] rxd;
        logic       hr;   logic       st;  logic       sp;
        logic       tf;   logic       rf;  logic [3:0] clr;
        int         etx;  int         erx; logic [3:0] efl; int elast;
    } vec_t;

    vec_t tbl[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        host_wr_en = 0; host_wdata = 0; host_rd_en = 0;
        i3c_rd_en = 0; i3c_wr_en = 0; i3c_rx_data = 0;
        start_detected = 0; stop_detected = 0;
        tx_flush = 0; rx_flush = 0; flag_clr = 0;
    endtask

    // Inputs are applied before the edge, outputs sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk_apb);
        #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk_apb);
        #1;
        rst_n = 1;
    endtask

    // Reference model state
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [3:0] m_flags;
    int         m_cnt, m_last;

    task automatic model_reset();
        tx_q.delete(); rx_q.delete();
        m_flags = 0; m_cnt = 0; m_last = 0;
    endtask

    task automatic model_step();
        logic [3:0] set;
        int n, moved;
        set = 0; moved = 0;
        if (tx_flush) tx_q.delete();
        else begin
            n = tx_q.size();
            if (i3c_rd_en) begin
                if (n == 0) set[1] = 1;
                else begin void'(tx_q.pop_front()); moved++; end
            end
            if (host_wr_en) begin
                if (n == DEPTH && !i3c_rd_en) set[0] = 1;
                else tx_q.push_back(host_wdata);
            end
        end
        if (rx_flush) rx_q.delete();
        else begin
            n = rx_q.size();
            if (host_rd_en) begin
                if (n == 0) set[3] = 1;
                else void'(rx_q.pop_front());
            end
            if (i3c_wr_en) begin
                if (n == DEPTH && !host_rd_en) set[2] = 1;
                else begin rx_q.push_back(i3c_rx_data); moved++; end
            end
        end
        m_flags = (m_flags & ~flag_clr) | set;
        if (stop_detected) m_last = (m_cnt + moved > 65535) ? 65535 : m_cnt + moved;
        if (start_detected) m_cnt = 0;
        else m_cnt = (m_cnt + moved > 65535) ? 65535 : m_cnt + moved;
    endtask

    task automatic model_compare();
        check("rnd_tx_level", tx_level, tx_q.size());
        check("rnd_rx_level", rx_level, rx_q.size());
        check("rnd_tx_data", i3c_tx_data, tx_q.size() > 0 ? tx_q[0] : 8'hFF);
        check("rnd_host_rdata", host_rdata, rx_q.size() > 0 ? rx_q[0] : 8'h00);
        check("rnd_tx_ready", i3c_tx_ready, tx_q.size() > 0);
        check("rnd_rx_ready", i3c_rx_ready, rx_q.size() < DEPTH);
        check("rnd_flags", flags, m_flags);
        check("rnd_last_len", last_xfer_len, m_last);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 0;
        do_reset();

        // Reset state
        check("rst_tx_level", tx_level, 0);
        check("rst_rx_level", rx_level, 0);
        check("rst_flags", flags, 0);
        check("rst_last_len", last_xfer_len, 0);
        check("rst_irq", irq, 0);
        check("rst_host_rdata", host_rdata, 8'h00);
        check("rst_tx_data", i3c_tx_data, 8'hFF);
        check("rst_tx_ready", i3c_tx_ready, 0);
        check("rst_rx_ready", i3c_rx_ready, 1);

        // Vector table: hw wd ir iw rxd hr st sp tf rf clr | tx rx flags last
        tbl[0]  = '{1, 8'hA1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4'h0, 1, 0, 4'h0, 0};
        tbl[1]  = '{1, 8'hA2, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4'h0, 2, 0, 4'h0, 0};
        tbl[2]  = '{1, 8'hA3, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4'h0, 3, 0, 4'h0, 0};
        tbl[3]  = '{1, 8'hA4, 0, 0, 8'h00, 0, 0, 0, 1, 0, 4'h0, 0, 0, 4'h0, 0};
        tbl[4]  = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0, 4'h0, 0, 0, 4'h2, 0};
        tbl[5]  = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 0, 4'h2, 0, 0, 4'h0, 0};
        tbl[6]  = '{0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 0, 0, 4'h0, 0, 0, 4'h0, 0};
        tbl[7]  = '{0, 8'h00, 0, 1, 8'h11, 0, 0, 0, 0, 0, 4'h0, 0, 1, 4'h0, 0};
        tbl[8]  = '{0, 8'h00, 0, 1, 8'h22, 0, 0, 0, 0, 0, 4'h0, 0, 2, 4'h0, 0};
        tbl[9]  = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 4'h0, 0, 1, 4'h0, 0};
        tbl[10] = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 4'h0, 0, 1, 4'h0, 2};
        tbl[11] = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 4'h0, 0, 0, 4'h0, 2};
        tbl[12] = '{0, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 0, 4'h0, 0, 0, 4'h8, 2};
        tbl[13] = '{0, 8'h00, 1, 0, 8'h00, 0, 0, 0, 0, 0, 4'hA, 0, 0, 4'h2, 2};
        tbl[14] = '{0, 8'h00, 0, 1, 8'h33, 0, 0, 0, 0, 0, 4'h0, 0, 1, 4'h2, 2};
        tbl[15] = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 1, 4'h0, 0, 0, 4'h2, 2};
        tbl[16] = '{0, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 0, 4'h0, 0, 0, 4'h2, 3};
        tbl[17] = '{0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0, 4'h0, 0, 0, 4'h2, 0};
        tbl[18] = '{1, 8'h05, 1, 0, 8'h00, 0, 0, 0, 0, 0, 4'h0, 1, 0, 4'h2, 0};

        for (int i = 0; i < 19; i++) begin
            host_wr_en = tbl[i].hw; host_wdata = tbl[i].wd;
            i3c_rd_en = tbl[i].ir; i3c_wr_en = tbl[i].iw; i3c_rx_data = tbl[i].rxd;
            host_rd_en = tbl[i].hr; start_detected = tbl[i].st; stop_detected = tbl[i].sp;
            tx_flush = tbl[i].tf; rx_flush = tbl[i].rf; flag_clr = tbl[i].clr;
            tick();
            check($sformatf("vec%0d_tx_level", i), tx_level, tbl[i].etx);
            check($sformatf("vec%0d_rx_level", i), rx_level, tbl[i].erx);
            check($sformatf("vec%0d_flags", i), flags, tbl[i].efl);
            check($sformatf("vec%0d_last_len", i), last_xfer_len, tbl[i].elast);
        end
        check("vec18_tx_head", i3c_tx_data, 8'h05);

        // TX fill to full, overflow, clear, drain in order, underrun
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            host_wr_en = 1; host_wdata = 8'(i);
            tick();
            check("tx_fill_level", tx_level, i + 1);
        end
        check("tx_full_ready", i3c_tx_ready, 1);
        host_wr_en = 1; host_wdata = 8'hEE;
        tick();
        check("tx_ovf_level", tx_level, DEPTH);
        check("tx_ovf_flag", flags, 4'b0001);
        flag_clr = 4'b0001;
        tick();
        check("tx_ovf_clear", flags, 4'b0000);
        for (int i = 0; i < DEPTH; i++) begin
            check("tx_drain_head", i3c_tx_data, 8'(i));
            i3c_rd_en = 1;
            tick();
            check("tx_drain_level", tx_level, DEPTH - 1 - i);
        end
        check("tx_drained_ready", i3c_tx_ready, 0);
        check("tx_drained_fill", i3c_tx_data, 8'hFF);
        i3c_rd_en = 1;
        tick();
        check("tx_udr_flag", flags, 4'b0010);
        check("tx_udr_data", i3c_tx_data, 8'hFF);
        check("tx_udr_level", tx_level, 0);

        // RX full with simultaneous push and pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            i3c_wr_en = 1; i3c_rx_data = 8'(8'h40 + i);
            tick();
        end
        check("rx_full_level", rx_level, DEPTH);
        check("rx_full_ready", i3c_rx_ready, 0);
        check("rx_full_head", host_rdata, 8'h40);
        i3c_wr_en = 1; i3c_rx_data = 8'h99; host_rd_en = 1;
        tick();
        check("rx_pp_level", rx_level, DEPTH);
        check("rx_pp_flags", flags, 4'b0000);
        for (int i = 1; i < DEPTH; i++) begin
            check("rx_drain_head", host_rdata, 8'(8'h40 + i));
            host_rd_en = 1;
            tick();
        end
        check("rx_tail_byte", host_rdata, 8'h99);
        host_rd_en = 1;
        tick();
        check("rx_empty_level", rx_level, 0);
        check("rx_empty_rdata", host_rdata, 8'h00);

        // Transfer counting across START/STOP
        do_reset();
        start_detected = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            i3c_wr_en = 1; i3c_rx_data = 8'(i);
            tick();
        end
        stop_detected = 1;
        tick();
        check("xfer_len_5", last_xfer_len, 5);
        for (int i = 0; i < 2; i++) begin
            i3c_wr_en = 1; i3c_rx_data = 8'(i);
            tick();
        end
        start_detected = 1; stop_detected = 1;
        tick();
        check("xfer_start_stop_len", last_xfer_len, 7);
        stop_detected = 1;
        tick();
        check("xfer_cnt_cleared", last_xfer_len, 0);

        // AUTO_TX_FLUSH discards unread TX bytes on STOP
        do_reset();
        for (int i = 0; i < 2; i++) begin
            host_wr_en = 1; host_wdata = 8'(8'hC0 + i);
            tick();
        end
        stop_detected = 1;
        tick();
        check("auto_flush_level", tx_level_2, 0);
        check("auto_flush_ready", i3c_tx_ready_2, 0);
        check("no_auto_flush_level", tx_level, 2);

        // Asynchronous reset mid-transfer
        host_wr_en = 1; host_wdata = 8'h77; i3c_rd_en = 1;
        tick();
        rst_n = 0;
        #2;
        check("async_rst_tx_level", tx_level, 0);
        check("async_rst_tx_data", i3c_tx_data, 8'hFF);
        check("async_rst_flags", flags, 0);
        @(posedge clk_apb);
        #1;
        rst_n = 1;

        // Randomized run against the queue model
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int pw, pr;
            pw = ((cyc / 64) % 2 == 0) ? 70 : 30;
            pr = 100 - pw;
            host_wr_en  = ($urandom_range(99) < pw);
            host_wdata  = 8'($urandom);
            i3c_rd_en   = ($urandom_range(99) < pr);
            i3c_wr_en   = ($urandom_range(99) < pw);
            i3c_rx_data = 8'($urandom);
            host_rd_en  = ($urandom_range(99) < pr);
            start_detected = ($urandom_range(99) < 3);
            stop_detected  = ($urandom_range(99) < 3);
            tx_flush = ($urandom_range(99) < 2);
            rx_flush = ($urandom_range(99) < 2);
            flag_clr = ($urandom_range(99) < 5) ? 4'($urandom) : 4'h0;
            if (start_detected || stop_detected) begin i3c_rd_en = 0; i3c_wr_en = 0; end
            if (tx_flush) i3c_rd_en = 0;
            if (rx_flush) host_rd_en = 0;
            model_step();
            tick();
            model_compare();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
